// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

    // Hazard response presented to the IF/ID/EX pipeline registers.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic flush_id;
        logic flush_ex;
    } hazard_ctrl_t;

endpackage

// File: rtl/perf_event_counter.sv
// Free-running event counter with enable and synchronous clear, wraps modulo 2^CNT_W.
// Latency: count reflects an event one clock after it is seen.
// Backpressure: none; the count is sampled whenever the reader likes.
//
// Ports: clk, clr (sync clear, wins over en), en (count this edge), cnt (current value).
module perf_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_detection_ctrl.sv
// Load-use and control hazard detection between ID and EX, plus perf counters.
// Latency: stall/flush outputs are combinational (0 cycles); counters update 1 cycle later.
// Backpressure: stall_if/stall_id hold the front end; the pipeline re-presents inputs while stalled.
//
// Ports: clk, rst (sync, active-high, clears counters only);
//        rs1_id/rs2_id (ID sources), rd_ex/mem_read_ex (EX destination, load flag),
//        branch_taken_ex/jump_ex (control transfer resolved in EX);
//        stall_if/stall_id/flush_id/flush_ex (hazard response);
//        load_use_cnt/ctrl_flush_cnt (event counters).
module hazard_detection_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 mem_read_ex,
    input  logic                 branch_taken_ex,
    input  logic                 jump_ex,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic [CNT_W-1:0]     load_use_cnt,
    output logic [CNT_W-1:0]     ctrl_flush_cnt
);

    logic         load_use;
    logic         ctrl;
    hazard_ctrl_t hz;

    // Only rd needs the x0 check: a source of x0 can only match an rd of x0,
    // which is already excluded here.
    assign load_use = mem_read_ex && (rd_ex != X0_IDX) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    assign ctrl     = branch_taken_ex || jump_ex;

    always_comb begin
        hz          = '0;
        hz.stall_if = load_use;
        hz.stall_id = load_use;
        hz.flush_ex = load_use || ctrl;
        // While stalling for load-use the IF/ID entry must be kept, so the
        // control flush of ID is held off; EX still gets its bubble.
        hz.flush_id = ctrl && !load_use;
    end

    assign stall_if = hz.stall_if;
    assign stall_id = hz.stall_id;
    assign flush_id = hz.flush_id;
    assign flush_ex = hz.flush_ex;

    perf_event_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .clk (clk),
        .clr (rst),
        .en  (load_use),
        .cnt (load_use_cnt)
    );

    perf_event_counter #(.CNT_W(CNT_W)) u_ctrl_flush_cnt (
        .clk (clk),
        .clr (rst),
        .en  (hz.flush_id),
        .cnt (ctrl_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_detection_ctrl.sv
module tb_hazard_detection_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       mem_read_ex, branch_taken_ex, jump_ex;

    logic        stall_if, stall_id, flush_id, flush_ex;
    logic [31:0] load_use_cnt, ctrl_flush_cnt;

    logic        w_stall_if, w_stall_id, w_flush_id, w_flush_ex;
    logic [3:0]  w_load_use_cnt, w_ctrl_flush_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    hazard_detection_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .load_use_cnt(load_use_cnt), .ctrl_flush_cnt(ctrl_flush_cnt)
    );

    hazard_detection_ctrl #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex),
        .stall_if(w_stall_if), .stall_id(w_stall_id), .flush_id(w_flush_id), .flush_ex(w_flush_ex),
        .load_use_cnt(w_load_use_cnt), .ctrl_flush_cnt(w_ctrl_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Hazard classification from the pipeline rules, and plain event tallies.
    int unsigned m_lu = 0;
    int unsigned m_cf = 0;

    function automatic bit is_load_use();
        if (!mem_read_ex) return 1'b0;
        if (rd_ex == 5'd0) return 1'b0;
        return (rd_ex == rs1_id) || (rd_ex == rs2_id);
    endfunction

    function automatic bit is_ctrl();
        return branch_taken_ex || jump_ex;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_lu <= 0;
            m_cf <= 0;
        end else begin
            if (is_load_use()) m_lu <= m_lu + 1;
            if (is_ctrl() && !is_load_use()) m_cf <= m_cf + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit lu, cf;
            lu = is_load_use();
            cf = is_ctrl() && !lu;
            check("stall_if",  {31'd0, stall_if},  {31'd0, lu});
            check("stall_id",  {31'd0, stall_id},  {31'd0, lu});
            check("flush_id",  {31'd0, flush_id},  {31'd0, cf});
            check("flush_ex",  {31'd0, flush_ex},  {31'd0, lu | is_ctrl()});
            check("w4_stalls", {28'd0, w_stall_if, w_stall_id, w_flush_id, w_flush_ex},
                               {28'd0, lu, lu, cf, lu | is_ctrl()});
            check("load_use_cnt",   load_use_cnt,   m_lu);
            check("ctrl_flush_cnt", ctrl_flush_cnt, m_cf);
            check("w4_load_use_cnt",   {28'd0, w_load_use_cnt},   m_lu % 16);
            check("w4_ctrl_flush_cnt", {28'd0, w_ctrl_flush_cnt}, m_cf % 16);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       mr, br, jmp;
        logic [2:0] exp;   // {stall, flush_id, flush_ex}
        string      name;
    } vec_t;

    vec_t vecs[18] = '{
        '{5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 3'b000, "no_hazard"},
        '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 3'b101, "lu_rs1"},
        '{5'd1,  5'd7,  5'd7,  1'b1, 1'b0, 1'b0, 3'b101, "lu_rs2"},
        '{5'd0,  5'd11, 5'd11, 1'b1, 1'b0, 1'b0, 3'b101, "lu_rs2_rs1x0"},
        '{5'd8,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 3'b101, "lu_both"},
        '{5'd31, 5'd30, 5'd31, 1'b1, 1'b0, 1'b0, 3'b101, "lu_max"},
        '{5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 3'b000, "load_nomatch"},
        '{5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 3'b000, "match_noload"},
        '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 3'b000, "load_x0_rs0"},
        '{5'd5,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 3'b000, "load_x0_rs5"},
        '{5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b0, 3'b011, "ctrl_br"},
        '{5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 3'b011, "ctrl_jmp"},
        '{5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b1, 3'b011, "ctrl_both"},
        '{5'd12, 5'd13, 5'd14, 1'b1, 1'b1, 1'b1, 3'b011, "ctrl_load_nomatch"},
        '{5'd9,  5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 3'b101, "prio_br"},
        '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 3'b101, "prio_jmp"},
        '{5'd9,  5'd0,  5'd9,  1'b1, 1'b1, 1'b1, 3'b101, "prio_both"},
        '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3'b000, "all_zero"}
    };

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic jmp);
        rs1_id = rs1; rs2_id = rs2; rd_ex = rd;
        mem_read_ex = mr; branch_taken_ex = br; jump_ex = jmp;
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_load_use_cnt",   load_use_cnt,   32'd0);
        check("reset_ctrl_flush_cnt", ctrl_flush_cnt, 32'd0);
        check("reset_outputs", {28'd0, stall_if, stall_id, flush_id, flush_ex}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;

        // Each vector is held for two clock edges.
        foreach (vecs[i]) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].jmp);
            @(negedge clk);
            check({vecs[i].name, "_outs"},
                  {28'd0, stall_if, stall_id, flush_id, flush_ex},
                  {28'd0, vecs[i].exp[2], vecs[i].exp[2], vecs[i].exp[1], vecs[i].exp[0]});
            @(posedge clk);
            @(posedge clk); #1;
        end

        // 8 load-use vectors and 4 control vectors, two edges each.
        @(negedge clk);
        check("table_load_use_cnt",      load_use_cnt,   32'd16);
        check("table_ctrl_flush_cnt",    ctrl_flush_cnt, 32'd8);
        check("table_w4_load_use_cnt",   {28'd0, w_load_use_cnt},   32'd0);
        check("table_w4_ctrl_flush_cnt", {28'd0, w_ctrl_flush_cnt}, 32'd8);

        // Reset mid-operation while a load-use hazard is presented.
        @(posedge clk); #1;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs_track", {28'd0, stall_if, stall_id, flush_id, flush_ex}, 32'hD);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cleared_lu", load_use_cnt,   32'd0);
        check("rst_cleared_cf", ctrl_flush_cnt, 32'd0);

        // Held stall: 4-bit counter reaches 15 then wraps to 0.
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("hold15_w4_lu", {28'd0, w_load_use_cnt}, 32'd15);
        check("hold15_lu",    load_use_cnt,            32'd15);
        @(posedge clk);
        @(negedge clk);
        check("wrap_w4_lu", {28'd0, w_load_use_cnt}, 32'd0);
        check("hold16_lu",  load_use_cnt,            32'd16);

        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_outs", {28'd0, stall_if, stall_id, flush_id, flush_ex}, 32'd0);
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
